// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared encodings, decode packet and immediate helper for the decode stage
package decode_pkg;

    // Instruction class carried in the decode packet
    typedef enum logic [2:0] {
        CLS_DP     = 3'd0,
        CLS_LS     = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_MUL    = 3'd3,
        CLS_SWI    = 3'd4,
        CLS_UNDEF  = 3'd7
    } instr_class_e;

    // Instruction type field [27:25]
    localparam logic [2:0] TYPE_DP_REG = 3'b000;
    localparam logic [2:0] TYPE_DP_IMM = 3'b001;
    localparam logic [2:0] TYPE_LS_IMM = 3'b010;
    localparam logic [2:0] TYPE_LS_REG = 3'b011;
    localparam logic [2:0] TYPE_BRANCH = 3'b101;
    localparam logic [2:0] TYPE_SWI    = 3'b111;

    // The "never" condition is treated as an undefined instruction
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [3:0]   cond;
        instr_class_e cls;
        logic [3:0]   opcode;
        logic         set_flags;
        logic [3:0]   rd;
        logic [3:0]   rn;
        logic [3:0]   rm;
        logic [3:0]   rs;
        logic         use_rs;
        logic         use_imm;
        logic [1:0]   shift;
        logic [4:0]   shift_amount;
        logic [31:0]  imm32;
        logic [11:0]  offset12;
        logic         p;
        logic         u;
        logic         b;
        logic         w;
        logic         l;
        logic         mem_access;
        logic         mem_write;
        logic         branch_link;
        logic [31:0]  branch_offset;
    } decode_pkt_t;

    // Rotate the zero-extended imm8 right by twice the rotate field
    function automatic logic [31:0] expand_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] dbl;
        logic [63:0] shifted;
        logic [5:0]  amt;
        amt     = {1'b0, rot, 1'b0};
        dbl     = {24'd0, imm8, 24'd0, imm8};
        shifted = dbl >> amt;
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - circular FIFO buffering fetched instructions ahead of decode
module decode_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o      = (count_q == CNT_FULL);
    assign empty_o     = (count_q == '0);
    assign head_data_o = mem_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Next-state pointers and occupancy; pointers wrap since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop) count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    // Pointer and count registers, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - queued ARM decode stage with registered decode packet
module instruction_decode_stage #(
    parameter int QUEUE_DEPTH      = 2,
    parameter int PC_WIDTH         = 32,
    parameter int SUPPORT_MULTIPLY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instruction,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [3:0]          out_cond,
    output logic [2:0]          out_class,
    output logic [3:0]          out_opcode,
    output logic                out_set_flags,
    output logic [3:0]          out_rd,
    output logic [3:0]          out_rn,
    output logic [3:0]          out_rm,
    output logic [3:0]          out_rs,
    output logic                out_use_rs,
    output logic                out_use_imm,
    output logic [1:0]          out_shift,
    output logic [4:0]          out_shift_amount,
    output logic [31:0]         out_imm32,
    output logic [11:0]         out_offset12,
    output logic                out_p,
    output logic                out_u,
    output logic                out_b,
    output logic                out_w,
    output logic                out_l,
    output logic                out_mem_access,
    output logic                out_mem_write,
    output logic                out_branch_link,
    output logic [31:0]         out_branch_offset
);
    import decode_pkg::*;

    localparam int QW = PC_WIDTH + 32;

    logic                q_push, q_pop, q_full, q_empty;
    logic [QW-1:0]       q_head;
    logic                in_fire, load;
    logic [31:0]         src_instr;
    logic [PC_WIDTH-1:0] src_pc;
    decode_pkt_t         pkt_d, pkt_q;
    logic                out_valid_q;
    logic [PC_WIDTH-1:0] out_pc_q;

    function automatic decode_pkt_t decode_instr(input logic [31:0] ins);
        decode_pkt_t p;
        logic [2:0]  ityp;
        p      = '0;
        p.cond = ins[31:28];
        p.cls  = CLS_UNDEF;
        ityp   = ins[27:25];
        if (ins[31:28] == COND_NV) begin
            p.cls = CLS_UNDEF;
        end else if (ityp == TYPE_DP_REG && ins[7:4] == 4'b1001 && ins[24:22] == 3'b000) begin
            if (SUPPORT_MULTIPLY != 0) begin
                p.cls       = CLS_MUL;
                p.rd        = ins[19:16];
                p.rn        = ins[15:12];
                p.rs        = ins[11:8];
                p.rm        = ins[3:0];
                p.set_flags = ins[20];
            end
        end else if (ityp == TYPE_DP_REG && ins[4] && ins[7]) begin
            p.cls = CLS_UNDEF;
        end else if (ityp == TYPE_DP_REG || ityp == TYPE_DP_IMM) begin
            p.cls       = CLS_DP;
            p.opcode    = ins[24:21];
            p.set_flags = ins[20];
            p.rn        = ins[19:16];
            p.rd        = ins[15:12];
            if (ityp == TYPE_DP_IMM) begin
                p.use_imm = 1'b1;
                p.imm32   = expand_imm(ins[7:0], ins[11:8]);
            end else begin
                p.use_rs = ins[4];
                if (ins[4]) p.rs = ins[11:8];
                else        p.shift_amount = ins[11:7];
                p.shift = ins[6:5];
                p.rm    = ins[3:0];
            end
        end else if (ityp == TYPE_LS_IMM || (ityp == TYPE_LS_REG && !ins[4])) begin
            p.cls        = CLS_LS;
            p.rn         = ins[19:16];
            p.rd         = ins[15:12];
            p.p          = ins[24];
            p.u          = ins[23];
            p.b          = ins[22];
            p.w          = ins[21];
            p.l          = ins[20];
            p.mem_access = 1'b1;
            p.mem_write  = !ins[20];
            if (ityp == TYPE_LS_IMM) begin
                p.offset12 = ins[11:0];
            end else begin
                p.rm           = ins[3:0];
                p.shift        = ins[6:5];
                p.shift_amount = ins[11:7];
            end
        end else if (ityp == TYPE_BRANCH) begin
            p.cls           = CLS_BRANCH;
            p.branch_link   = ins[24];
            p.branch_offset = {{6{ins[23]}}, ins[23:0], 2'b00};
        end else if (ityp == TYPE_SWI && ins[24]) begin
            p.cls = CLS_SWI;
        end
        return p;
    endfunction

    decode_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (QW)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (q_push),
        .push_data_i ({in_pc, in_instruction}),
        .pop_i       (q_pop),
        .head_data_o (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    assign in_ready = !q_full;
    assign in_fire  = in_valid && in_ready;

    // The packet register refills whenever it is free or being consumed and something is available;
    // with an empty queue the incoming instruction bypasses straight into it
    assign load   = !flush && (!out_valid_q || out_ready) && (!q_empty || in_fire);
    assign q_pop  = load && !q_empty;
    assign q_push = in_fire && !(load && q_empty);

    assign src_instr = q_empty ? in_instruction : q_head[31:0];
    assign src_pc    = q_empty ? in_pc : q_head[QW-1:32];

    // Combinational decode of whichever instruction is about to be loaded
    always_comb begin
        pkt_d = decode_instr(src_instr);
    end

    // Output packet register: holds while stalled, clears on reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            pkt_q       <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= src_pc;
            pkt_q       <= pkt_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_pc            = out_pc_q;
    assign out_cond          = pkt_q.cond;
    assign out_class         = pkt_q.cls;
    assign out_opcode        = pkt_q.opcode;
    assign out_set_flags     = pkt_q.set_flags;
    assign out_rd            = pkt_q.rd;
    assign out_rn            = pkt_q.rn;
    assign out_rm            = pkt_q.rm;
    assign out_rs            = pkt_q.rs;
    assign out_use_rs        = pkt_q.use_rs;
    assign out_use_imm       = pkt_q.use_imm;
    assign out_shift         = pkt_q.shift;
    assign out_shift_amount  = pkt_q.shift_amount;
    assign out_imm32         = pkt_q.imm32;
    assign out_offset12      = pkt_q.offset12;
    assign out_p             = pkt_q.p;
    assign out_u             = pkt_q.u;
    assign out_b             = pkt_q.b;
    assign out_w             = pkt_q.w;
    assign out_l             = pkt_q.l;
    assign out_mem_access    = pkt_q.mem_access;
    assign out_mem_write     = pkt_q.mem_write;
    assign out_branch_link   = pkt_q.branch_link;
    assign out_branch_offset = pkt_q.branch_offset;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - scoreboard bench for the instruction decode stage
module tb_instruction_decode_stage;

    typedef struct packed {
        logic [3:0]  cond;
        logic [2:0]  cls;
        logic [3:0]  opcode;
        logic        sf;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic        use_rs;
        logic        use_imm;
        logic [1:0]  shift;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [11:0] off;
        logic [4:0]  pubwl;
        logic        macc;
        logic        mw;
        logic        link;
        logic [31:0] boff;
    } exp_pkt_t;

    typedef struct {
        logic [31:0] pc;
        int          idx;
    } sb_t;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instruction = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, in_ready_nm, out_valid_nm;
    logic [31:0] out_pc, out_pc_nm;
    exp_pkt_t    obs, obs_nm;

    logic [31:0] ins_tbl [N];
    exp_pkt_t    exp_tbl [N];
    exp_pkt_t    exp_nm_tbl [N];
    sb_t         sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_decode_stage #(.QUEUE_DEPTH(2), .PC_WIDTH(32), .SUPPORT_MULTIPLY(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_cond(obs.cond), .out_class(obs.cls), .out_opcode(obs.opcode),
        .out_set_flags(obs.sf), .out_rd(obs.rd), .out_rn(obs.rn), .out_rm(obs.rm),
        .out_rs(obs.rs), .out_use_rs(obs.use_rs), .out_use_imm(obs.use_imm),
        .out_shift(obs.shift), .out_shift_amount(obs.shamt), .out_imm32(obs.imm),
        .out_offset12(obs.off), .out_p(obs.pubwl[4]), .out_u(obs.pubwl[3]),
        .out_b(obs.pubwl[2]), .out_w(obs.pubwl[1]), .out_l(obs.pubwl[0]),
        .out_mem_access(obs.macc), .out_mem_write(obs.mw),
        .out_branch_link(obs.link), .out_branch_offset(obs.boff)
    );

    instruction_decode_stage #(.QUEUE_DEPTH(2), .PC_WIDTH(32), .SUPPORT_MULTIPLY(0)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nm),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid_nm), .out_ready(out_ready), .out_pc(out_pc_nm),
        .out_cond(obs_nm.cond), .out_class(obs_nm.cls), .out_opcode(obs_nm.opcode),
        .out_set_flags(obs_nm.sf), .out_rd(obs_nm.rd), .out_rn(obs_nm.rn), .out_rm(obs_nm.rm),
        .out_rs(obs_nm.rs), .out_use_rs(obs_nm.use_rs), .out_use_imm(obs_nm.use_imm),
        .out_shift(obs_nm.shift), .out_shift_amount(obs_nm.shamt), .out_imm32(obs_nm.imm),
        .out_offset12(obs_nm.off), .out_p(obs_nm.pubwl[4]), .out_u(obs_nm.pubwl[3]),
        .out_b(obs_nm.pubwl[2]), .out_w(obs_nm.pubwl[1]), .out_l(obs_nm.pubwl[0]),
        .out_mem_access(obs_nm.macc), .out_mem_write(obs_nm.mw),
        .out_branch_link(obs_nm.link), .out_branch_offset(obs_nm.boff)
    );

    function automatic exp_pkt_t mk(
        input logic [3:0] cond, input logic [2:0] cls, input logic [3:0] opcode, input logic sf,
        input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
        input logic use_rs, input logic use_imm, input logic [1:0] shift, input logic [4:0] shamt,
        input logic [31:0] imm, input logic [11:0] off, input logic [4:0] pubwl,
        input logic macc, input logic mw, input logic link, input logic [31:0] boff);
        return {cond, cls, opcode, sf, rd, rn, rm, rs, use_rs, use_imm, shift, shamt,
                imm, off, pubwl, macc, mw, link, boff};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic consume();
        sb_t s;
        if (sb.size() == 0) begin
            check("spurious_out_valid", 128'(out_valid), 128'(1'b0));
        end else begin
            s = sb.pop_front();
            check("out_pc", 128'(out_pc), 128'(s.pc));
            check("out_class", 128'(obs.cls), 128'(exp_tbl[s.idx].cls));
            check("packet", 128'(obs), 128'(exp_tbl[s.idx]));
            check("nomul_valid", 128'(out_valid_nm), 128'(1'b1));
            check("nomul_pc", 128'(out_pc_nm), 128'(s.pc));
            check("nomul_packet", 128'(obs_nm), 128'(exp_nm_tbl[s.idx]));
        end
    endtask

    task automatic cycle(input logic v, input int idx, input logic [31:0] pc,
                         input logic ordy, input logic fl, output logic accepted);
        @(negedge clk);
        in_valid       = v;
        in_instruction = ins_tbl[idx];
        in_pc          = pc;
        out_ready      = ordy;
        flush          = fl;
        #1;
        accepted = v && in_ready && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) consume();
            if (accepted) sb.push_back('{pc, idx});
        end
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int c = 0; c < 50 && sb.size() > 0; c++) cycle(1'b0, 0, 32'h0, 1'b1, 1'b0, acc);
        check(tag, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   n_cyc;
        int   sent;

        ins_tbl[0] = 32'hE3A004FF;  ins_tbl[1] = 32'hE0810312;
        ins_tbl[2] = 32'hE5921004;  ins_tbl[3] = 32'hE5821004;
        ins_tbl[4] = 32'hEBFFFFFE;  ins_tbl[5] = 32'hE0000291;
        ins_tbl[6] = 32'hF0000000;  ins_tbl[7] = 32'hE1A01102;
        ins_tbl[8] = 32'hEF000011;  ins_tbl[9] = 32'hE7912103;
        exp_tbl[0] = mk(4'hE, 3'd0, 4'hD, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFF000000, 0, 5'b0, 0, 0, 0, 0);
        exp_tbl[1] = mk(4'hE, 3'd0, 4'h4, 0, 0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 0);
        exp_tbl[2] = mk(4'hE, 3'd1, 4'h0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 12'd4, 5'b11001, 1, 0, 0, 0);
        exp_tbl[3] = mk(4'hE, 3'd1, 4'h0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 12'd4, 5'b11000, 1, 1, 0, 0);
        exp_tbl[4] = mk(4'hE, 3'd2, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 1, 32'hFFFFFFF8);
        exp_tbl[5] = mk(4'hE, 3'd3, 4'h0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 0);
        exp_tbl[6] = mk(4'hF, 3'd7, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 0);
        exp_tbl[7] = mk(4'hE, 3'd0, 4'hD, 0, 1, 0, 2, 0, 0, 0, 0, 5'd2, 0, 0, 5'b0, 0, 0, 0, 0);
        exp_tbl[8] = mk(4'hE, 3'd4, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 0);
        exp_tbl[9] = mk(4'hE, 3'd1, 4'h0, 0, 2, 1, 3, 0, 0, 0, 0, 5'd2, 0, 0, 5'b11001, 1, 0, 0, 0);
        for (int i = 0; i < N; i++) exp_nm_tbl[i] = exp_tbl[i];
        exp_nm_tbl[5] = mk(4'hE, 3'd7, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_pc", 128'(out_pc), 128'(0));
        check("rst_packet", 128'(obs), 128'(0));
        check("rst_in_ready_nomul", 128'(in_ready_nm), 128'(1'b1));
        check("rst_packet_nomul", 128'(obs_nm), 128'(0));

        // Streaming with out_ready high: one-cycle latency and full throughput
        for (int k = 0; k < N; k++) begin
            cycle(1'b1, k, 32'h1000 + 32'(4 * k), 1'b1, 1'b0, acc);
            check("stream_accept", 128'(acc), 128'(1'b1));
            if (k >= 1) check("stream_valid", 128'(out_valid), 128'(1'b1));
        end
        drain("stream_drain");

        // Backpressure: one in the packet register plus two queued
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, k, 32'h3000 + 32'(4 * k), 1'b0, 1'b0, acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", 128'(n_acc), 128'(3));
        check("bp_in_ready", 128'(in_ready), 128'(1'b0));
        n_cyc = 0;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            cycle(1'b0, 0, 32'h0, 1'b1, 1'b0, acc);
            n_cyc++;
        end
        check("bp_drain_cycles", 128'(n_cyc), 128'(3));

        // Flush with queue full, packet valid and an input offered in the flush cycle
        for (int k = 0; k < 6 && in_ready; k++) cycle(1'b1, k + 4, 32'h4000 + 32'(4 * k), 1'b0, 1'b0, acc);
        check("flush_pre_full", 128'(in_ready), 128'(1'b0));
        check("flush_pre_valid", 128'(out_valid), 128'(1'b1));
        cycle(1'b1, 0, 32'hDEAD0000, 1'b0, 1'b1, acc);
        cycle(1'b0, 0, 32'h0, 1'b1, 1'b0, acc);
        check("flush_out_valid", 128'(out_valid), 128'(1'b0));
        check("flush_in_ready", 128'(in_ready), 128'(1'b1));
        repeat (5) cycle(1'b0, 0, 32'h0, 1'b1, 1'b0, acc);

        // Random valid/ready traffic through the whole instruction table
        sent = 0;
        for (int c = 0; c < 600 && sent < 40; c++) begin
            cycle(1'($urandom_range(0, 3) != 0), sent % N, 32'h8000 + 32'(4 * sent),
                  1'($urandom_range(0, 2) != 0), 1'b0, acc);
            if (acc) sent++;
        end
        check("random_sent", 128'(sent), 128'(40));
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
